// File: rtl/serial_shift_register.sv
// rtl/serial_shift_register.sv - parameterised serial-in/serial-out delay line
module serial_shift_register #(
   parameter int WIDTH = 6
) (
   output logic so,
   input  logic clk,
   input  logic reset,
   input  logic si
);

   logic [WIDTH-1:0] stage;

   // Stage 0 takes si; every other stage takes its predecessor on the same edge.
   generate
      if (WIDTH == 1) begin : g_single
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               stage <= '0;
            end else begin
               stage <= si;
            end
         end
      end else begin : g_chain
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               stage <= '0;
            end else begin
               stage <= {stage[WIDTH-2:0], si};
            end
         end
      end
   endgenerate

   assign so = stage[WIDTH-1];

endmodule

// File: tb/tb_serial_shift_register.sv
// tb/tb_serial_shift_register.sv - scoreboard bench for three delay-line widths
module tb_serial_shift_register;

   typedef struct {
      logic e1;
      logic e4;
      logic e6;
      string tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic si = 1'b0;
   logic so1, so4, so6;

   int errors = 0;
   int checks = 0;

   exp_t sb[$];
   logic hist[$];

   serial_shift_register #(1) dut1 (.so(so1), .clk(clk), .reset(reset), .si(si));
   serial_shift_register #(4) dut4 (.so(so4), .clk(clk), .reset(reset), .si(si));
   serial_shift_register      dut6 (.so(so6), .clk(clk), .reset(reset), .si(si));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   // Reference: output after an edge is the sample taken W edges back counting
   // the current one; history after reset is padded with zeros.
   function automatic logic delayed(input int w);
      return hist[hist.size() - w];
   endfunction

   task automatic flush_hist();
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);
   endtask

   // Set inputs mid-cycle, record what the next rising edge must produce.
   task automatic cycle(input logic r, input logic s, input string tag);
      exp_t e;
      reset = r;
      si = s;
      if (!r) begin
         flush_hist();
      end else begin
         hist.push_back(s);
         void'(hist.pop_front());
      end
      e.e1 = delayed(1);
      e.e4 = delayed(4);
      e.e6 = delayed(6);
      e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      check("async_so1", so1, 1'b0);
      check("async_so4", so4, 1'b0);
      check("async_so6", so6, 1'b0);
      flush_hist();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_w1"}, so1, e.e1);
            check({e.tag, "_w4"}, so4, e.e4);
            check({e.tag, "_w6"}, so6, e.e6);
         end
      end
   end

   initial begin : driver
      logic seq[11];
      seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      flush_hist();

      // Held in reset with si high: nothing may load.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, "reset_hold");

      for (int i = 0; i < 11; i++) cycle(1'b1, seq[i], "directed");
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, "drain");

      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, "all_ones");
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, "all_zeros");

      // Fill with ones, then drop reset between edges.
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, "prefill");
      async_reset();
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, "mid_reset");
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, "post_reset");

      cycle(1'b1, 1'b1, "walk_one");
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, "walk_one");

      for (int i = 0; i < 12; i++) cycle(1'b1, i[0], "toggle");

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset();
            cycle(1'b0, 1'($urandom), "rand_reset");
         end else begin
            cycle(1'b1, 1'($urandom), "random");
         end
      end

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_shift_register.md
Name: serial_shift_register

Overview:
Parameterised serial-in/serial-out (SISO) shift register: one bit enters per clock and leaves WIDTH clocks later. It is a pure delay line for single-bit serial streams, used as a pipeline delay or deserialiser front end. The module contains no parallel load and no parallel output.

Parameters:
WIDTH, 6, number of flip-flop stages, i.e. the delay in clock cycles from si to so. Legal range is WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; reset=0 clears all stages
so  output  1  serial data out, driven directly by the last stage flop
si  input  1  serial data in, sampled on the rising edge of clk
Positional port order is fixed as (so, clk, reset, si). Instances in the codebase connect positionally.

Behaviour:
- One clock domain (clk). reset is asynchronous and active-low.
- Internal state: stage[WIDTH-1:0], all registered, no combinational path from si to so.
- Reset:
  - While reset=0, all stages are forced to 0 immediately, independent of clk.
  - so=0 during reset.
  - Assertion mid-stream discards all in-flight bits.
- Deassertion: the first rising edge of clk with reset=1 samples si into stage[0].
- On each rising edge of clk with reset=1:
  - stage[0] <= si.
  - stage[i] <= stage[i-1] for i = 1..WIDTH-1.
  - so = stage[WIDTH-1] at all times.
- Latency: a bit sampled on edge k appears on so right after edge k+WIDTH-1. The output has exactly WIDTH register stages, so si→so delay is WIDTH cycles counted from the sampling edge.
- WIDTH=1 degenerates to a single D flop: so follows si one edge later.
- No enable. Every non-reset edge shifts.
- Data is never altered: no inversion and no reordering.
- si must be stable around the rising edge of clk. Testbenches change si mid-cycle (clock period 10 time units, si changes on edges of a 10-unit grid offset from the clock edges).
- During reset, the leading WIDTH outputs after deassertion are 0, because they are flushed-in reset zeros.
- Do not add extra outputs or ports. Parameter override by position (#(n)) must select WIDTH.

Test Plan:
1. Reset, WIDTH=4: hold reset=0 with si=1 across several clk edges -> so stays 0 and no stage loads. Release reset -> so=0 for the next 3 edges.
2. Delay check, WIDTH=4, after reset: drive si = 1,0,0,1,0,1,0,0,0,1,1 on successive edges -> so reproduces the same sequence, each bit appearing on the 4th edge after it was sampled. Before that, so=0.
3. Async reset mid-stream: fill with 1111, then pull reset=0 between clock edges -> so drops to 0 immediately, without waiting for clk. After release, so stays 0 until newly sampled bits arrive.
4. Walking one, default WIDTH=6: single si=1 pulse followed by zeros -> so=1 for exactly one cycle, 6 edges after sampling.
5. WIDTH=1: toggle si every edge -> so equals si delayed by one clock edge.
6. All-ones then all-zeros, WIDTH=4: 8 edges of si=1, then si=0 -> so goes high on edge 4, low again on the 4th edge after the first 0.
